rsi_arbiter: RTL and testbench
==============================

# rsi_arbiter

Shares the single combinational `rsi` threshold unit between `N_CH` independent symbol channels. Each channel offers a 32-bit RSI value over a valid/ready handshake. A round-robin arbiter picks one channel per cycle and drives the instance's `RSI` input. The `out1`/`out2` flags are registered together with the channel id and a per-channel change flag, and handed downstream to the order-decision logic over a second valid/ready handshake.

## Interface
- `N_CH`, 4, number of requesting channels (≥2)
- `W`, 32, RSI word width; must match `rsi.RSI`
- `ID_W`, `$clog2(N_CH)`, channel-id width

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `req_valid`  in  N_CH  channel i has an RSI value pending
- `req_rsi`  in  N_CH*W  channel i value at bits [i*W +: W]
- `req_ready`  out  N_CH  one-hot accept; channel i transfer = `req_valid[i] & req_ready[i]`
- `res_valid`  out  1  result register holds a result
- `res_ready`  in  1  downstream accepts the result
- `res_id`  out  ID_W  channel the result belongs to
- `res_rsi`  out  W  RSI value that was evaluated
- `res_out1`  out  1  `rsi.out1` (overbought, RSI > 70)
- `res_out2`  out  1  `rsi.out2` (oversold, RSI < 30)
- `res_changed`  out  1  {out1,out2} differs from that channel's previous result

## Operation
- Issue enable: `issue = !res_valid | res_ready`.
  - When `issue` is high and any `req_valid` is set, grant the first valid channel at or after `rr_ptr`, searching upward with wrap N_CH-1→0.
  - Exactly that bit of `req_ready` is high, combinationally in the same cycle.
  - `req_ready` is all-zero when `issue` is low or no request is present.
- `rsi` instance input: mux of `req_rsi` at the granted index. When there is no grant, drive the lowest valid channel's value, or 0 if none is valid; output is don't-care.
- On a grant to channel g, at the next edge:
  - load `res_id`=g, `res_rsi`, `res_out1`, `res_out2`.
  - `res_changed` = ({out1,out2} != last_sig[g]) | !seen[g].
  - `last_sig[g]` ← {out1,out2}; `seen[g]` ← 1.
  - `rr_ptr` ← (g+1) mod N_CH.
  - `res_valid` ← 1.
- On `res_valid & res_ready` with no new grant, `res_valid` ← 0.
- Accept and new grant in the same cycle: the result register is overwritten. No bubble; full throughput of 1 result/cycle.
- Backpressure (`res_valid & !res_ready`): all result fields hold stable, no grants, and `rr_ptr` holds.
- A requester may drop `req_valid` without a transfer. No request is remembered.
- Values with `out1` and `out2` both set cannot occur; pass through whatever `rsi` returns.

## Timing
- Reset values: `res_valid`=0, `res_id`=0, `res_rsi`=0, `res_out1`=0, `res_out2`=0, `res_changed`=0, `req_ready`=0 (combinational, follows `res_valid`=0 and no requests), `rr_ptr`=0, `last_sig`=all 00, `seen`=all 0.
- Latency: request transfer in cycle n produces `res_valid` in cycle n+1.
- Fairness: with all N_CH channels continuously valid and `res_ready`=1, grants cycle 0,1,…,N_CH-1,0; each channel waits ≤ N_CH-1 cycles.
- Reset asserted mid-operation: all state clears immediately. A pending result is lost, and `last_sig`/`seen` are forgotten.
- `rsi` is combinational. The critical path is `req_valid` → priority search → mux → `rsi` → result register, all in one cycle.

## Structure
- Shared package `hft_pkg`: `RSI_W`=32, `RSI_HI`=70 and `RSI_LO`=30 constants, and the signal encoding {out1,out2}: 10=SELL, 01=BUY, 00=HOLD.
- Sub-module `rr_arbiter` (N, ptr in, req in → one-hot grant, grant index, any). It is reusable for other shared FPU units.
- Instantiates the existing `rsi` unit once. No internal FSM beyond the result-register full/empty bit and `rr_ptr`.

## Test plan
- Reset then single request: ch2 with RSI=80, `res_ready`=1 → next cycle `res_valid`=1, `res_id`=2, out1=1, out2=0, `res_changed`=1; `rr_ptr`=3.
- Round-robin: all 4 channels valid with RSI = 10, 50, 75, 29 and `res_ready`=1 for 8 cycles → `res_id` sequence 0,1,2,3,0,1,2,3; signals 01,00,10,01; `res_changed` is 1 on the first lap and 0 on the second.
- Backpressure: `res_ready`=0 for 3 cycles while ch1 is valid → `req_ready`=0, result fields stable. Raising `res_ready` → ch1 granted the same cycle and new result the next cycle.
- Change detect: ch0 sends 80, 85, 25, 50 → `res_changed` 1,0,1,1; signals 10,10,01,00.
- Wrap/skip: `rr_ptr`=3 with only ch3 and ch1 valid → grant ch3 then ch1 (wrap past 0).
- Async reset mid-stream: assert `rst_n`=0 between edges while `res_valid`=1 → all outputs 0 immediately. After release, ch0 RSI=80 reports `res_changed`=1.

Source files
------------

// File: rtl/hft_pkg.sv
// -----------------------------------------------------------------------------
// hft_pkg
// Shared constants and encodings for the trading-signal datapath.
//   RSI_W   : width of an RSI word
//   RSI_HI  : overbought threshold (RSI strictly above this raises out1)
//   RSI_LO  : oversold threshold (RSI strictly below this raises out2)
//   sig_e   : {out1,out2} signal encoding handed to order-decision logic
// -----------------------------------------------------------------------------
package hft_pkg;

  localparam int RSI_W  = 32;
  localparam int RSI_HI = 70;
  localparam int RSI_LO = 30;

  // {out1,out2}; 2'b11 is not produced by the threshold unit
  typedef enum logic [1:0] {
    SIG_HOLD = 2'b00,
    SIG_BUY  = 2'b01,
    SIG_SELL = 2'b10
  } sig_e;

  function automatic logic [1:0] pack_sig(input logic out1, input logic out2);
    return {out1, out2};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker, reusable for any shared unit.
// Grants the first requester at or above ptr, wrapping from N-1 back to 0.
//   ptr       in  ID_W  highest-priority index this cycle
//   req       in  N     request vector
//   grant     out N     one-hot grant (all-zero when no request)
//   grant_idx out ID_W  index of the granted requester (0 when none)
//   any       out 1     a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [ID_W-1:0] ptr,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);

  // First pass covers ptr..N-1; the second pass only matters when nothing
  // at or above ptr is requesting, giving the wrap to the low indices.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rsi.sv
// -----------------------------------------------------------------------------
// rsi
// Combinational RSI threshold unit.
//   RSI  in  RSI_W  relative-strength value
//   out1 out  1     overbought (RSI > RSI_HI)
//   out2 out  1     oversold   (RSI < RSI_LO)
// -----------------------------------------------------------------------------
module rsi
  import hft_pkg::*;
(
  input  logic [RSI_W-1:0] RSI,
  output logic             out1,
  output logic             out2
);

  assign out1 = (RSI > RSI_W'(RSI_HI));
  assign out2 = (RSI < RSI_W'(RSI_LO));

endmodule

// File: rtl/rsi_arbiter.sv
// -----------------------------------------------------------------------------
// rsi_arbiter
// Shares one combinational rsi threshold unit between N_CH symbol channels.
// A round-robin arbiter selects one channel per cycle; the thresholded result
// is registered with the channel id and a per-channel change flag, and offered
// downstream over a valid/ready handshake.
//   clk         in  1       clock, rising edge
//   rst_n       in  1       asynchronous active-low reset
//   req_valid   in  N_CH    channel i has a value pending
//   req_rsi     in  N_CH*W  channel i value at [i*W +: W]
//   req_ready   out N_CH    one-hot accept
//   res_valid   out 1       result register full
//   res_ready   in  1       downstream accepts result
//   res_id      out ID_W    channel of the result
//   res_rsi     out W       evaluated RSI value
//   res_out1    out 1       overbought flag
//   res_out2    out 1       oversold flag
//   res_changed out 1       {out1,out2} differs from channel's last result
// -----------------------------------------------------------------------------
module rsi_arbiter
  import hft_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = RSI_W,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH*W-1:0] req_rsi,
  output logic [N_CH-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_id,
  output logic [W-1:0]      res_rsi,
  output logic              res_out1,
  output logic              res_out2,
  output logic              res_changed
);

  logic [ID_W-1:0] rr_ptr;
  logic [1:0]      last_sig [N_CH];
  logic [N_CH-1:0] seen;

  logic            issue;
  logic [N_CH-1:0] arb_req;
  logic [N_CH-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic [W-1:0]    rsi_in;
  logic            rsi_out1;
  logic            rsi_out2;
  logic [1:0]      cur_sig;
  logic            changed_next;
  logic [ID_W-1:0] ptr_next;

  // A new result may be loaded when the register is empty or being drained.
  assign issue   = !res_valid | res_ready;
  assign arb_req = issue ? req_valid : '0;

  rr_arbiter #(
    .N    (N_CH),
    .ID_W (ID_W)
  ) u_arb (
    .ptr       (rr_ptr),
    .req       (arb_req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ready = grant;

  // Without a grant the unit's output is ignored, but the lowest valid
  // channel is still steered in so the input is never floating.
  always_comb begin
    rsi_in = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        rsi_in = req_rsi[i*W +: W];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        rsi_in = req_rsi[i*W +: W];
      end
    end
  end

  rsi u_rsi (
    .RSI  (rsi_in),
    .out1 (rsi_out1),
    .out2 (rsi_out2)
  );

  assign cur_sig = pack_sig(rsi_out1, rsi_out2);

  // First result of a channel since reset always counts as a change.
  always_comb begin
    changed_next = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        changed_next = (cur_sig != last_sig[i]) | !seen[i];
      end
    end
  end

  assign ptr_next = (grant_idx == ID_W'(N_CH - 1)) ? '0 : grant_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_rsi     <= '0;
      res_out1    <= 1'b0;
      res_out2    <= 1'b0;
      res_changed <= 1'b0;
      rr_ptr      <= '0;
      seen        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        last_sig[i] <= 2'b00;
      end
    end else begin
      if (grant_any) begin
        res_valid   <= 1'b1;
        res_id      <= grant_idx;
        res_rsi     <= rsi_in;
        res_out1    <= rsi_out1;
        res_out2    <= rsi_out2;
        res_changed <= changed_next;
        rr_ptr      <= ptr_next;
        for (int i = 0; i < N_CH; i++) begin
          if (grant[i]) begin
            last_sig[i] <= cur_sig;
            seen[i]     <= 1'b1;
          end
        end
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rsi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rsi_arbiter
// Self-checking bench for rsi_arbiter (N_CH=4, W=32). Expected results are
// queued when a grant is expected and compared when the result register
// should present them.
// -----------------------------------------------------------------------------
module tb_rsi_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_rsi;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [31:0]  res_rsi;
  logic         res_out1;
  logic         res_out2;
  logic         res_changed;

  rsi_arbiter #(
    .N_CH (4),
    .W    (32),
    .ID_W (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rsi     (req_rsi),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_rsi     (res_rsi),
    .res_out1    (res_out1),
    .res_out2    (res_out2),
    .res_changed (res_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] rsi;
    logic [1:0]  sig;
    logic        changed;
  } exp_t;

  typedef struct packed {
    logic [3:0]   valid;
    logic [127:0] bus;
    logic         ready;
    logic [3:0]   exp_ready;
    logic [1:0]   exp_sig;
    logic         exp_changed;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  logic exp_valid;
  logic exp_valid_next;
  logic pushed;
  int   checks;
  int   failures;
  vec_t vecs [17];

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, check the combinational accept, queue the
  // expected result when a grant is expected, then wait for the edge.
  task automatic applyStimulus(input logic [3:0] valid, input logic [127:0] bus,
                               input logic ready, input logic [3:0] exp_ready,
                               input logic [1:0] exp_sig, input logic exp_changed);
    exp_t e;
    int   idx;
    req_valid = valid;
    req_rsi   = bus;
    res_ready = ready;
    #1;
    check("req_ready", {60'd0, req_ready}, {60'd0, exp_ready});
    pushed = 1'b0;
    if (exp_ready != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (exp_ready[i]) idx = i;
      e.id      = 2'(idx);
      e.rsi     = bus[idx*32 +: 32];
      e.sig     = exp_sig;
      e.changed = exp_changed;
      exp_q.push_back(e);
      pushed         = 1'b1;
      exp_valid_next = 1'b1;
    end else if (ready) begin
      exp_valid_next = 1'b0;
    end else begin
      exp_valid_next = exp_valid;
    end
    @(posedge clk);
  endtask

  task automatic checkOutput();
    #1;
    if (pushed) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    exp_valid = exp_valid_next;
    check("res_valid", {63'd0, res_valid}, {63'd0, exp_valid});
    if (exp_valid) begin
      check("res_id", {62'd0, res_id}, {62'd0, cur_exp.id});
      check("res_rsi", {32'd0, res_rsi}, {32'd0, cur_exp.rsi});
      check("res_sig", {62'd0, res_out1, res_out2}, {62'd0, cur_exp.sig});
      check("res_changed", {63'd0, res_changed}, {63'd0, cur_exp.changed});
    end
  endtask

  task automatic step(input logic [3:0] valid, input logic [127:0] bus, input logic ready,
                      input logic [3:0] exp_ready, input logic [1:0] exp_sig,
                      input logic exp_changed);
    applyStimulus(valid, bus, ready, exp_ready, exp_sig, exp_changed);
    checkOutput();
  endtask

  task automatic checkReset();
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_id", {62'd0, res_id}, 64'd0);
    check("rst_res_rsi", {32'd0, res_rsi}, 64'd0);
    check("rst_res_out", {62'd0, res_out1, res_out2}, 64'd0);
    check("rst_res_changed", {63'd0, res_changed}, 64'd0);
    check("rst_req_ready", {60'd0, req_ready}, 64'd0);
    exp_q.delete();
    exp_valid      = 1'b0;
    exp_valid_next = 1'b0;
    pushed         = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    exp_valid      = 1'b0;
    exp_valid_next = 1'b0;
    pushed         = 1'b0;
    cur_exp        = '0;
    req_valid      = 4'b0000;
    req_rsi        = '0;
    res_ready      = 1'b0;
    rst_n          = 1'b1;

    // Round-robin lap twice, then the change-detect and threshold-boundary
    // sequence on channel 0 alone.
    for (int i = 0; i < 8; i++) begin
      vecs[i].valid       = 4'b1111;
      vecs[i].bus         = pack4(32'd10, 32'd50, 32'd75, 32'd29);
      vecs[i].ready       = 1'b1;
      vecs[i].exp_ready   = 4'b0001 << (i % 4);
      vecs[i].exp_changed = (i < 4);
    end
    vecs[0].exp_sig = 2'b01;
    vecs[1].exp_sig = 2'b00;
    vecs[2].exp_sig = 2'b10;
    vecs[3].exp_sig = 2'b01;
    vecs[4].exp_sig = 2'b01;
    vecs[5].exp_sig = 2'b00;
    vecs[6].exp_sig = 2'b10;
    vecs[7].exp_sig = 2'b01;
    vecs[8]  = '{4'b0001, pack4(32'd80, 0, 0, 0), 1'b1, 4'b0001, 2'b10, 1'b1};
    vecs[9]  = '{4'b0001, pack4(32'd85, 0, 0, 0), 1'b1, 4'b0001, 2'b10, 1'b0};
    vecs[10] = '{4'b0001, pack4(32'd25, 0, 0, 0), 1'b1, 4'b0001, 2'b01, 1'b1};
    vecs[11] = '{4'b0001, pack4(32'd50, 0, 0, 0), 1'b1, 4'b0001, 2'b00, 1'b1};
    vecs[12] = '{4'b0001, pack4(32'd70, 0, 0, 0), 1'b1, 4'b0001, 2'b00, 1'b0};
    vecs[13] = '{4'b0001, pack4(32'd30, 0, 0, 0), 1'b1, 4'b0001, 2'b00, 1'b0};
    vecs[14] = '{4'b0001, pack4(32'd71, 0, 0, 0), 1'b1, 4'b0001, 2'b10, 1'b1};
    vecs[15] = '{4'b0001, pack4(32'd29, 0, 0, 0), 1'b1, 4'b0001, 2'b01, 1'b1};
    vecs[16] = '{4'b0001, pack4(32'd80, 0, 0, 0), 1'b1, 4'b0001, 2'b10, 1'b1};

    // Reset
    #1 rst_n = 1'b0;
    #1 checkReset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request on ch2, then drain
    step(4'b0100, pack4(0, 0, 32'd80, 0), 1'b1, 4'b0100, 2'b10, 1'b1);
    step(4'b0000, '0, 1'b1, 4'b0000, 2'b00, 1'b0);

    // rr_ptr is 3: ch3 first, then wrap past 0 to ch1
    step(4'b1010, pack4(0, 32'd50, 0, 32'd29), 1'b1, 4'b1000, 2'b01, 1'b1);
    step(4'b1010, pack4(0, 32'd50, 0, 32'd29), 1'b1, 4'b0010, 2'b00, 1'b1);

    // Backpressure: fields hold, no accept; release grants ch1 same cycle
    for (int i = 0; i < 3; i++)
      step(4'b0010, pack4(0, 32'd60, 0, 0), 1'b0, 4'b0000, 2'b00, 1'b0);
    step(4'b0010, pack4(0, 32'd60, 0, 0), 1'b1, 4'b0010, 2'b00, 1'b0);
    step(4'b0000, '0, 1'b1, 4'b0000, 2'b00, 1'b0);

    // Fresh state for fairness lap
    rst_n = 1'b0;
    #1 checkReset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++)
      step(vecs[i].valid, vecs[i].bus, vecs[i].ready, vecs[i].exp_ready,
           vecs[i].exp_sig, vecs[i].exp_changed);

    // Async reset between edges while a result is pending
    req_valid = 4'b0000;
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkReset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // History forgotten: same value as before reset reports a change
    step(4'b0001, pack4(32'd80, 0, 0, 0), 1'b1, 4'b0001, 2'b10, 1'b1);
    step(4'b0000, '0, 1'b1, 4'b0000, 2'b00, 1'b0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
